// File: rtl/wb_sdram_arbiter.sv
// Two-master round-robin Wishbone B3 arbiter sharing the SDRAM controller slave port.
// Define WB_SDRAM_ARB_WATCHDOG_EN to add the stall watchdog (err pulse + ABORT state).
`timescale 1ns/1ps
module wb_sdram_arbiter #(
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,

  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,

  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,

  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,

  output logic [1:0]      gnt_o
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;
`ifdef WB_SDRAM_ARB_WATCHDOG_EN
  localparam logic [1:0] ABORT = 2'b11;
`endif

  logic [1:0] state, state_nxt;
  logic       last, last_nxt;
  logic       own0, own1;

  assign own0 = (state == GNT0);
  assign own1 = (state == GNT1);

`ifdef WB_SDRAM_ARB_WATCHDOG_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt;
  logic        wd_stall, timeout, abort_err;

  assign wd_stall = s_stb_o && !s_ack_i && !s_err_i;
  assign timeout  = wd_stall && (wd_cnt == TO_LAST);

  // abort_err is high only in the first ABORT cycle, giving a one-cycle err pulse
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wd_cnt    <= '0;
      abort_err <= 1'b0;
    end else begin
      abort_err <= (state != ABORT) && (state_nxt == ABORT);
      if (wd_stall && (state_nxt == state)) wd_cnt <= wd_cnt + 16'd1;
      else                                  wd_cnt <= '0;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last)) state_nxt = GNT0;
        else if (m1_cyc_i)                   state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
`ifdef WB_SDRAM_ARB_WATCHDOG_EN
        else if (timeout) state_nxt = ABORT;
`endif
      end
      GNT1: begin
        if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
`ifdef WB_SDRAM_ARB_WATCHDOG_EN
        else if (timeout) state_nxt = ABORT;
`endif
      end
`ifdef WB_SDRAM_ARB_WATCHDOG_EN
      // last still names the aborted owner; release follows the GNTx handover rule
      ABORT: begin
        if (last) begin
          if (!m1_cyc_i) state_nxt = m0_cyc_i ? GNT0 : IDLE;
        end else begin
          if (!m0_cyc_i) state_nxt = m1_cyc_i ? GNT1 : IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == GNT0)      last_nxt = 1'b0;
    else if (state_nxt == GNT1) last_nxt = 1'b1;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_cti_o = m0_cti_i;
      s_bte_o = m0_bte_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_cti_o = m1_cti_i;
      s_bte_o = m1_bte_i;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = own0 && s_ack_i;
  assign m1_ack_o = own1 && s_ack_i;

`ifdef WB_SDRAM_ARB_WATCHDOG_EN
  assign m0_err_o = (own0 && s_err_i) || (abort_err && !last);
  assign m1_err_o = (own1 && s_err_i) || (abort_err && last);
  assign gnt_o    = (state == ABORT) ? (last ? 2'b10 : 2'b01) : {own1, own0};
`else
  assign m0_err_o = own0 && s_err_i;
  assign m1_err_o = own1 && s_err_i;
  assign gnt_o    = {own1, own0};
`endif

endmodule
